// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue
// Brief   : DEPTH-entry {pc, instr} FIFO between IF and the IF/ID boundary,
//           with one-cycle flush and a NOP bubble when empty.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013,
    parameter int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       flush_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]    r_mem_pc    [DEPTH];
    logic [XLEN-1:0]    r_mem_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [15:0]        r_flush_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full is judged on registered occupancy only: a full queue refuses a
    // push even when the head is being consumed in the same cycle.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & ~w_full & ~flush;
    assign w_pop   = ~w_empty & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_flush_cnt <= '0;
        end else if (flush) begin
            // Dropping everything is just catching the read pointer up.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
            if (r_flush_cnt != 16'hFFFF) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign out_pc    = w_empty ? '0        : r_mem_pc[r_rd_ptr];
    assign out_instr = w_empty ? NOP_INSTR : r_mem_instr[r_rd_ptr];
    assign count     = r_count;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction fetch queue placed between the IF stage and the IF/ID boundary of the 5-stage RISC-V pipeline.
- Replaces the single-entry IF/ID hand-off with a DEPTH-entry FIFO of {pc, instr} pairs.
- IF keeps fetching while ID is stalled. A taken branch flushes every queued entry in one cycle.
- When empty, the queue presents a NOP bubble to ID.

Parameters:
- XLEN, 32, width of pc and instr fields.
- DEPTH, 4, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction driven on out_instr when the queue is empty or in reset (addi x0,x0,0).
- CNT_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-low (0 = reset).
- in_valid  in  1  IF presents a fetched instruction this cycle.
- in_pc  in  XLEN  PC of the fetched instruction.
- in_instr  in  XLEN  fetched instruction word.
- in_ready  out  1  queue accepts a push this cycle.
- out_valid  out  1  head entry is valid.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  XLEN  head instruction, or NOP_INSTR when out_valid=0.
- out_ready  in  1  ID consumes the head this cycle (driven as !stall).
- flush  in  1  branch_taken from ID; discards all entries.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- flush_cnt  out  16  number of flush events since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0 at clock edge):
  - wr_ptr, rd_ptr, count and flush_cnt go to 0.
  - Outputs: out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1 from the first cycle after reset.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all entries and takes priority over flush, push and pop.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- in_ready = (count != DEPTH). It is combinational from registered count and does not look ahead to a same-cycle pop. Result: when full, a push is refused even if a pop happens in that cycle.
- out_valid = (count != 0).
  - out_pc / out_instr come from mem[rd_ptr] (first-word fall-through, combinational read of registered storage).
  - When out_valid=0: out_pc=0, out_instr=NOP_INSTR.
- Latency: a pushed entry becomes visible at out_* on the cycle after the push edge. There is no same-cycle in->out bypass.
- Push writes mem[wr_ptr] and advances wr_ptr. Pop advances rd_ptr. Both pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Empty and ID ready: pop is suppressed (out_valid=0) and count stays 0, so no underflow.
- Flush (highest priority after reset):
  - In a flush cycle, rd_ptr <= wr_ptr and count <= 0. in_valid and out_ready are ignored that cycle.
  - out_valid=0 on the next cycle.
  - flush_cnt increments by 1 unless it is already at 16'hFFFF.
- Flush held for multiple cycles keeps the queue empty and counts once per asserted cycle.
- Pushes resume normally in the first cycle with flush=0, carrying the branch-target fetch from IF.
- Entries are never reordered or duplicated. Pop order equals push order.

Test Plan:
- Reset/empty: hold rst=0 for 2 cycles, then release. Required: count=0, out_valid=0, out_instr=32'h00000013, in_ready=1, flush_cnt=0.
- Fill and stall, DEPTH=4, out_ready=0: push pc=0x00,0x04,0x08,0x0C with instr=0x00500093,0x00A00113,0x002081B3,0x00302023.
  - After the 4th push: count=4, in_ready=0.
  - A 5th push (pc=0x10) is refused and count stays 4.
  - out_pc=0x00 throughout.
- Drain in order: from full, set out_ready=1, in_valid=0 for 4 cycles. Required: out_pc sequence 0x00,0x04,0x08,0x0C; then out_valid=0, count=0, out_instr=NOP.
- Simultaneous push/pop with wrap: continuous in_valid=1 and out_ready=1 for 12 cycles, pc stepping by 4 from 0x100.
  - count settles at 1 and pointers wrap 3 times.
  - Every pc from 0x100 to 0x12C appears exactly once, in order, one cycle after its push.
- Flush priority: queue holds 3 entries; assert flush with in_valid=1 (pc=0x40) and out_ready=1.
  - Next cycle: count=0, out_valid=0, flush_cnt=1, and pc 0x40 never appears.
  - The following push pc=0x80 is visible at out_pc one cycle later.
- Reset mid-operation: with count=2 and flush=1, drive rst=0 for one cycle. Required: count=0, flush_cnt=0, out_valid=0, in_ready=1.
